// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and the oversample default shared with the transmitter
package uart_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the raw serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rxs
);
  logic r_meta;
  logic r_sync;
  // Resample the asynchronous line twice before anyone looks at it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_sync, r_meta} <= 2'b11;
    else        {r_sync, r_meta} <= {r_meta, i_rx};
  assign o_rxs = r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; optional parity bit enabled by UART_RX_PARITY_EN
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_t            r_state, w_state_nx;
  logic [TW-1:0]        r_tcnt, w_tcnt_nx;
  logic [BW-1:0]        r_bcnt, w_bcnt_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx, r_data, w_data_nx;
  logic                 r_valid, w_valid_nx, r_ferr, w_ferr_nx;
  logic                 w_rxs, w_tmax, w_thalf, w_par_bad;
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .i_rx(rx), .o_rxs(w_rxs));
  assign w_tmax  = r_tcnt == TW'(OVERSAMPLE - 1);
  assign w_thalf = r_tcnt == TW'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_PARITY_EN
  logic r_par_bad, w_par_bad_nx, r_perr, w_perr_nx;
  assign w_par_bad  = r_par_bad;
  assign parity_err = r_perr;
  // Parity verdict is latched when the parity bit is sampled; the error pulse follows the stop sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_par_bad, r_perr} <= 2'b00;
    else        {r_par_bad, r_perr} <= {w_par_bad_nx, w_perr_nx};
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif
  // Frame sequencing: everything advances only on oversample ticks; pulses default low each clk
  always_comb begin
    w_state_nx = r_state;
    w_tcnt_nx  = r_tcnt;
    w_bcnt_nx  = r_bcnt;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nx = r_par_bad;
    w_perr_nx    = 1'b0;
`endif
    if (rx_tick) begin
      w_tcnt_nx = r_tcnt + 1'b1;
      case (r_state)
        IDLE:
          if (!w_rxs) begin
            w_state_nx = START;
            w_tcnt_nx  = '0;
          end
        START:
          if (w_thalf) begin
            w_state_nx = w_rxs ? IDLE : DATA;
            w_tcnt_nx  = '0;
            w_bcnt_nx  = '0;
          end
        DATA:
          if (w_tmax) begin
            w_tcnt_nx  = '0;
            w_bcnt_nx  = r_bcnt + 1'b1;
            w_shift_nx = {w_rxs, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            if (r_bcnt == BW'(DATA_BITS - 1)) w_state_nx = PARITY;
`else
            if (r_bcnt == BW'(DATA_BITS - 1)) w_state_nx = STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (w_tmax) begin
            w_tcnt_nx    = '0;
            w_par_bad_nx = w_rxs ^ (^r_shift) ^ (PARITY_ODD != 0);
            w_state_nx   = STOP;
          end
`endif
        STOP:
          if (w_tmax) begin
            w_tcnt_nx  = '0;
            w_data_nx  = r_shift;
            w_valid_nx = w_rxs & ~w_par_bad;
            w_ferr_nx  = ~w_rxs;
`ifdef UART_RX_PARITY_EN
            w_perr_nx  = r_par_bad;
`endif
            w_state_nx = w_rxs ? IDLE : BRK;
          end
        BRK:
          if (w_rxs) w_state_nx = IDLE;
        default:
          w_state_nx = IDLE;
      endcase
    end
  end
  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '1;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
    end
  assign data       = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at rx_tick every 4 clk (64 clk per bit); UART_RX_PARITY_EN adds parity cases
module tb_uart_rx;
  logic       clk = 0, rst_n = 0, rx_tick = 0, rx = 1;
  logic [7:0] data;
  logic       data_valid, frame_err, parity_err, busy;
  int checks = 0, errors = 0;
  int nv = 0, nf = 0, np = 0, tc = 0;
  int bv, bf, bp;
`ifdef UART_RX_PARITY_EN
  localparam bit PE = 1;
`else
  localparam bit PE = 0;
`endif

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rx(rx), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tc++;
    rx_tick = (tc % 4 == 0);
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) nv++;
    if (frame_err === 1'b1) nf++;
    if (parity_err === 1'b1) np++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input int par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (par >= 0) bit_out(par[0]);
  endtask

  task automatic send(input logic [7:0] d, input int par);
    send_body(d, par);
    bit_out(1'b1);
  endtask

  function automatic int pb(input logic [7:0] d);
    return PE ? int'(^d) : -1;
  endfunction

  task automatic mark;
    bv = nv; bf = nf; bp = np;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    repeat (10) @(negedge clk);

    mark();
    send(8'hA5, pb(8'hA5));
    repeat (20) @(negedge clk);
    chk("a5_nvalid", nv - bv, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_nferr", nf - bf, 0);
    chk("a5_busy", busy, 0);

    mark();
    rx = 0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    rx = 1;
    repeat (64) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_nvalid", nv - bv, 0);
    chk("glitch_nferr", nf - bf, 0);
    chk("glitch_data", data, 8'hA5);

    mark();
    send_body(8'h3C, pb(8'h3C));
    rx = 0;
    repeat (128) @(negedge clk);
    chk("brk_nferr", nf - bf, 1);
    chk("brk_nvalid", nv - bv, 0);
    chk("brk_data", data, 8'h3C);
    chk("brk_busy", busy, 1);
    rx = 1;
    repeat (64) @(negedge clk);
    chk("brk_exit_busy", busy, 0);
    mark();
    send(8'h11, pb(8'h11));
    repeat (20) @(negedge clk);
    chk("post_brk_nvalid", nv - bv, 1);
    chk("post_brk_data", data, 8'h11);
    chk("post_brk_nferr", nf - bf, 0);

    mark();
    send(8'h00, pb(8'h00));
    chk("b2b_first", data, 8'h00);
    send(8'hFF, pb(8'hFF));
    repeat (20) @(negedge clk);
    chk("b2b_second", data, 8'hFF);
    chk("b2b_nvalid", nv - bv, 2);
    chk("b2b_nferr", nf - bf, 0);

    mark();
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    repeat (10) @(negedge clk);
    chk("midrst_busy_pre", busy, 1);
    rst_n = 0;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_busy", busy, 0);
    rx = 1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (70) @(negedge clk);
    chk("midrst_nvalid", nv - bv, 0);
    send(8'h81, pb(8'h81));
    repeat (20) @(negedge clk);
    chk("after_rst_data", data, 8'h81);
    chk("after_rst_nvalid", nv - bv, 1);

`ifdef UART_RX_PARITY_EN
    mark();
    send(8'h07, 1);
    repeat (20) @(negedge clk);
    chk("par_ok_nvalid", nv - bv, 1);
    chk("par_ok_nperr", np - bp, 0);
    chk("par_ok_data", data, 8'h07);
    mark();
    send(8'h07, 0);
    repeat (20) @(negedge clk);
    chk("par_bad_nperr", np - bp, 1);
    chk("par_bad_nvalid", nv - bv, 0);
    chk("par_bad_nferr", nf - bf, 0);
`else
    chk("noparity_perr_count", np, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
